// File: rtl/dma_csr_axil_slave_if.sv
// AXI4-Lite bundle for the DMA CSR slave; the master modport drives requests, the slave modport answers them.
interface dma_csr_axil_slave_if #(
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/dma_csr_axil_slave.sv
// AXI4-Lite CSR block for a DMA engine: CTRL, STATUS, IRQ_STS, DESC_ADDR, TAIL_ADDR.
// Define DMA_CSR_SCRATCH_EN to add a 32-bit SCRATCH register at offset 0x14.
module dma_csr_axil_slave #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   dma_csr_axil_slave_if.slave  s_axil,
   output logic                 ctrl_run,
   output logic                 soft_rst_pulse,
   output logic [31:0]          desc_addr,
   output logic [31:0]          tail_addr,
   output logic                 tail_wr_pulse,
   input  logic                 sts_busy,
   input  logic                 sts_halted,
   input  logic                 evt_done,
   input  logic                 evt_err,
   output logic                 irq
);

   if (ADDR_WIDTH < 5 || DATA_WIDTH != 32) begin : g_cfg_check
      $error("dma_csr_axil_slave: ADDR_WIDTH must be >= 5 and DATA_WIDTH must be 32");
   end

   typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] A_CTRL    = 3'd0;
   localparam logic [2:0] A_STATUS  = 3'd1;
   localparam logic [2:0] A_IRQ     = 3'd2;
   localparam logic [2:0] A_DESC    = 3'd3;
   localparam logic [2:0] A_TAIL    = 3'd4;
   localparam logic [2:0] A_SCRATCH = 3'd5;

   wr_state_t   r_wstate, w_wstate_nxt;
   rd_state_t   r_rstate, w_rstate_nxt;

   logic        r_run, r_irq_en, r_done, r_err, r_irq;
   logic        r_soft_pulse, r_tail_pulse;
   logic [31:0] r_desc, r_tail, r_rdata;
   logic [1:0]  r_bresp, r_rresp;
`ifdef DMA_CSR_SCRATCH_EN
   logic [31:0] r_scratch;
`endif

   logic        w_wr_fire, w_rd_fire, w_wr_mapped, w_rd_mapped;
   logic [2:0]  w_wr_idx, w_rd_idx;
   logic [1:0]  w_irq_clr;
   logic [31:0] w_rd_data;

   function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
      logic [31:0] v;
      v = old_v;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
      end
      return v;
   endfunction

   always_comb begin
      w_wstate_nxt   = r_wstate;
      s_axil.awready = 1'b0;
      s_axil.wready  = 1'b0;
      s_axil.bvalid  = 1'b0;
      case (r_wstate)
         W_IDLE: if (s_axil.awvalid && s_axil.wvalid) w_wstate_nxt = W_ACK;
         W_ACK: begin
            s_axil.awready = 1'b1;
            s_axil.wready  = 1'b1;
            w_wstate_nxt   = W_RESP;
         end
         W_RESP: begin
            s_axil.bvalid = 1'b1;
            if (s_axil.bready) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rstate_nxt   = r_rstate;
      s_axil.arready = 1'b0;
      s_axil.rvalid  = 1'b0;
      case (r_rstate)
         R_IDLE: if (s_axil.arvalid) w_rstate_nxt = R_ACK;
         R_ACK: begin
            s_axil.arready = 1'b1;
            w_rstate_nxt   = R_DATA;
         end
         R_DATA: begin
            s_axil.rvalid = 1'b1;
            if (s_axil.rready) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   assign w_wr_fire = (r_wstate == W_ACK);
   assign w_rd_fire = (r_rstate == R_ACK);
   assign w_wr_idx  = s_axil.awaddr[4:2];
   assign w_rd_idx  = s_axil.araddr[4:2];
   assign w_irq_clr = (w_wr_fire && w_wr_idx == A_IRQ && s_axil.wstrb[0]) ? s_axil.wdata[1:0] : '0;

   always_comb begin
      w_wr_mapped = 1'b1;
      case (w_wr_idx)
         A_CTRL, A_STATUS, A_IRQ, A_DESC, A_TAIL: w_wr_mapped = 1'b1;
`ifdef DMA_CSR_SCRATCH_EN
         A_SCRATCH: w_wr_mapped = 1'b1;
`endif
         default: w_wr_mapped = 1'b0;
      endcase
   end

   // STATUS is taken straight from the DMA pins at the R_ACK edge
   always_comb begin
      w_rd_data   = '0;
      w_rd_mapped = 1'b1;
      case (w_rd_idx)
         A_CTRL:   w_rd_data = {29'd0, r_irq_en, 1'b0, r_run};
         A_STATUS: w_rd_data = {30'd0, sts_halted, sts_busy};
         A_IRQ:    w_rd_data = {30'd0, r_err, r_done};
         A_DESC:   w_rd_data = r_desc;
         A_TAIL:   w_rd_data = r_tail;
`ifdef DMA_CSR_SCRATCH_EN
         A_SCRATCH: w_rd_data = r_scratch;
`endif
         default:  w_rd_mapped = 1'b0;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_run        <= 1'b0;
         r_irq_en     <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_irq        <= 1'b0;
         r_soft_pulse <= 1'b0;
         r_tail_pulse <= 1'b0;
         r_desc       <= '0;
         r_tail       <= '0;
         r_rdata      <= '0;
         r_bresp      <= '0;
         r_rresp      <= '0;
`ifdef DMA_CSR_SCRATCH_EN
         r_scratch    <= '0;
`endif
      end else begin
         r_soft_pulse <= 1'b0;
         r_tail_pulse <= 1'b0;
         // a new event outranks a simultaneous W1C clear
         r_done       <= (r_done & ~w_irq_clr[0]) | evt_done;
         r_err        <= (r_err  & ~w_irq_clr[1]) | evt_err;
         r_irq        <= r_irq_en & (r_done | r_err);
         if (w_wr_fire) begin
            r_bresp <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
            case (w_wr_idx)
               A_CTRL: if (s_axil.wstrb[0]) begin
                  r_run        <= s_axil.wdata[0];
                  r_soft_pulse <= s_axil.wdata[1];
                  r_irq_en     <= s_axil.wdata[2];
               end
               A_DESC: r_desc <= f_merge(r_desc, s_axil.wdata, s_axil.wstrb);
               A_TAIL: begin
                  r_tail       <= f_merge(r_tail, s_axil.wdata, s_axil.wstrb);
                  r_tail_pulse <= |s_axil.wstrb;
               end
`ifdef DMA_CSR_SCRATCH_EN
               A_SCRATCH: r_scratch <= f_merge(r_scratch, s_axil.wdata, s_axil.wstrb);
`endif
               default: ;
            endcase
         end
         if (w_rd_fire) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign s_axil.bresp  = r_bresp;
   assign s_axil.rdata  = r_rdata;
   assign s_axil.rresp  = r_rresp;
   assign ctrl_run       = r_run;
   assign soft_rst_pulse = r_soft_pulse;
   assign desc_addr      = r_desc;
   assign tail_addr      = r_tail;
   assign tail_wr_pulse  = r_tail_pulse;
   assign irq            = r_irq;

endmodule

// File: tb/tb_dma_csr_axil_slave.sv
// Directed plus randomized bench for dma_csr_axil_slave against a register-level reference model.
module tb_dma_csr_axil_slave;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        ctrl_run, soft_rst_pulse, tail_wr_pulse, irq;
   logic [31:0] desc_addr, tail_addr;
   logic        sts_busy, sts_halted, evt_done, evt_err;

   always #5 ACLK = ~ACLK;

   dma_csr_axil_slave_if #(.ADDR_WIDTH(32)) axil ();

   dma_csr_axil_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .s_axil(axil),
      .ctrl_run(ctrl_run), .soft_rst_pulse(soft_rst_pulse),
      .desc_addr(desc_addr), .tail_addr(tail_addr), .tail_wr_pulse(tail_wr_pulse),
      .sts_busy(sts_busy), .sts_halted(sts_halted),
      .evt_done(evt_done), .evt_err(evt_err), .irq(irq)
   );

   int checks = 0;
   int errors = 0;

   // Pulse monitor: counts high cycles so a pulse longer than one cycle is caught
   int          tail_pulses = 0;
   int          soft_pulses = 0;
   logic [31:0] tail_at_pulse = '0;
   always @(negedge ACLK) begin
      if (tail_wr_pulse) begin
         tail_pulses++;
         tail_at_pulse = tail_addr;
      end
      if (soft_rst_pulse) soft_pulses++;
   end

   // Reference model: architectural register contents only
   bit          m_run, m_irq_en, m_done, m_err;
   logic [31:0] m_desc, m_tail, m_scr;

   task automatic model_reset();
      m_run = 0; m_irq_en = 0; m_done = 0; m_err = 0;
      m_desc = '0; m_tail = '0; m_scr = '0;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] v;
      v = old_v;
      for (int i = 0; i < 4; i++) if (strb[i]) v[8*i +: 8] = new_v[8*i +: 8];
      return v;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp, output int tpulse, output int spulse);
      int unsigned idx;
      idx = (addr >> 2) & 7;
      resp = 2'b00; tpulse = 0; spulse = 0;
      case (idx)
         0: if (strb[0]) begin
               m_run = data[0]; m_irq_en = data[2]; spulse = data[1] ? 1 : 0;
            end
         1: ;
         2: if (strb[0]) begin
               if (data[0]) m_done = 0;
               if (data[1]) m_err = 0;
            end
         3: m_desc = merge(m_desc, data, strb);
         4: begin m_tail = merge(m_tail, data, strb); tpulse = (strb != 0) ? 1 : 0; end
`ifdef DMA_CSR_SCRATCH_EN
         5: m_scr = merge(m_scr, data, strb);
`endif
         default: resp = 2'b10;
      endcase
   endtask

   task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
      int unsigned idx;
      idx = (addr >> 2) & 7;
      d = '0; resp = 2'b00;
      case (idx)
         0: d = {29'd0, m_irq_en, 1'b0, m_run};
         1: d = {30'd0, sts_halted, sts_busy};
         2: d = {30'd0, m_err, m_done};
         3: d = m_desc;
         4: d = m_tail;
`ifdef DMA_CSR_SCRATCH_EN
         5: d = m_scr;
`endif
         default: resp = 2'b10;
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, "_ctrl_run"}, 32'(ctrl_run), 32'(m_run));
      check({tag, "_desc_addr"}, desc_addr, m_desc);
      check({tag, "_tail_addr"}, tail_addr, m_tail);
      check({tag, "_irq"}, 32'(irq), 32'(m_irq_en && (m_done || m_err)));
   endtask

   task automatic wait_sig(input string tag, input int which);
      int n;
      logic s;
      n = 0;
      s = (which == 0) ? axil.awready : (which == 1) ? axil.bvalid :
          (which == 2) ? axil.arready : axil.rvalid;
      while (!s && n < 20) begin
         @(negedge ACLK);
         n++;
         s = (which == 0) ? axil.awready : (which == 1) ? axil.bvalid :
             (which == 2) ? axil.arready : axil.rvalid;
      end
      if (!s) check({tag, "_timeout"}, 32'(s), 32'd1);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit evt_at_ack, output logic [1:0] resp);
      axil.awaddr = addr; axil.wdata = data; axil.wstrb = strb;
      axil.awvalid = 1; axil.wvalid = 1;
      @(negedge ACLK);
      wait_sig("awready", 0);
      check("wready_with_awready", 32'(axil.wready), 32'd1);
      if (evt_at_ack) evt_done = 1;
      @(negedge ACLK);
      evt_done = 0;
      axil.awvalid = 0; axil.wvalid = 0; axil.bready = 1;
      wait_sig("bvalid", 1);
      resp = axil.bresp;
      @(negedge ACLK);
      axil.bready = 0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      axil.araddr = addr; axil.arvalid = 1;
      @(negedge ACLK);
      wait_sig("arready", 2);
      @(negedge ACLK);
      axil.arvalid = 0; axil.rready = 1;
      wait_sig("rvalid", 3);
      data = axil.rdata; resp = axil.rresp;
      @(negedge ACLK);
      axil.rready = 0;
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit evt_at_ack);
      logic [1:0] resp, exp_resp;
      int t0, s0, tp, sp;
      t0 = tail_pulses; s0 = soft_pulses;
      axi_write(addr, data, strb, evt_at_ack, resp);
      model_write(addr, data, strb, exp_resp, tp, sp);
      if (evt_at_ack) m_done = 1;
      @(negedge ACLK);
      check({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
      check({tag, "_tail_pulses"}, 32'(tail_pulses - t0), 32'(tp));
      check({tag, "_soft_pulses"}, 32'(soft_pulses - s0), 32'(sp));
      if (tp != 0) check({tag, "_tail_at_pulse"}, tail_at_pulse, m_tail);
      check_outs(tag);
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr);
      logic [31:0] d, exp_d;
      logic [1:0]  resp, exp_resp;
      sts_busy = 1'($urandom_range(0, 1));
      sts_halted = 1'($urandom_range(0, 1));
      model_read(addr, exp_d, exp_resp);
      axi_read(addr, d, resp);
      check({tag, "_rdata"}, d, exp_d);
      check({tag, "_rresp"}, 32'(resp), 32'(exp_resp));
   endtask

   task automatic pulse_evt(input bit d, input bit e);
      evt_done = d; evt_err = e;
      if (d) m_done = 1;
      if (e) m_err = 1;
      @(negedge ACLK);
      evt_done = 0; evt_err = 0;
      @(negedge ACLK);
   endtask

   initial begin
      logic [1:0]  resp, exp_resp;
      int          t0, tp, sp;
      int unsigned op, idx;
      logic [31:0] addr, data;

      ARESET = 1;
      sts_busy = 0; sts_halted = 0; evt_done = 0; evt_err = 0;
      axil.awaddr = '0; axil.awvalid = 0; axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 0;
      axil.bready = 0; axil.araddr = '0; axil.arvalid = 0; axil.rready = 0;
      model_reset();
      repeat (3) @(negedge ACLK);

      check("rst_awready", 32'(axil.awready), 32'd0);
      check("rst_bvalid", 32'(axil.bvalid), 32'd0);
      check("rst_rvalid", 32'(axil.rvalid), 32'd0);
      check("rst_soft_pulse", 32'(soft_rst_pulse), 32'd0);
      check("rst_tail_pulse", 32'(tail_wr_pulse), 32'd0);
      check_outs("rst");
      ARESET = 0;
      @(negedge ACLK);

      do_write("desc_full", 32'h0C, 32'hDEAD_BEEF, 4'hF, 0);
      do_read("desc_full", 32'h0C);

      do_write("tail", 32'h10, 32'h0000_1000, 4'hF, 0);
      do_write("desc_half", 32'h0C, 32'h1111_2222, 4'h3, 0);
      do_read("desc_half", 32'h0C);
      check("desc_half_value", desc_addr, 32'hDEAD_2222);

      do_write("ctrl7", 32'h00, 32'h0000_0007, 4'hF, 0);
      do_read("ctrl7", 32'h00);

      pulse_evt(1, 0);
      check_outs("evt_done");
      do_read("irq_set", 32'h08);
      do_write("irq_clr_vs_set", 32'h08, 32'h1, 4'hF, 1);
      do_read("irq_after_race", 32'h08);
      do_write("irq_clr", 32'h08, 32'h1, 4'hF, 0);
      do_read("irq_cleared", 32'h08);
      pulse_evt(0, 1);
      do_write("irq_clr_err", 32'h08, 32'h2, 4'hF, 0);

      do_read("unmapped_1c", 32'h1C);
      do_read("off_14", 32'h14);
      do_read("status", 32'h04);
      do_write("unmapped_wr", 32'h1C, 32'hFFFF_FFFF, 4'hF, 0);
      do_write("status_wr", 32'h04, 32'hFFFF_FFFF, 4'hF, 0);
      do_write("desc_strb0", 32'h0C, 32'h0BAD_0BAD, 4'h0, 0);
      do_read("desc_after", 32'h0C);

      // Back-pressure: hold bready low with a second write already presented
      t0 = tail_pulses;
      axil.awaddr = 32'h0C; axil.wdata = 32'hA5A5_0001; axil.wstrb = 4'hF;
      axil.awvalid = 1; axil.wvalid = 1; axil.bready = 0;
      @(negedge ACLK);
      wait_sig("stall_awready", 0);
      @(negedge ACLK);
      model_write(32'h0C, 32'hA5A5_0001, 4'hF, exp_resp, tp, sp);
      axil.awaddr = 32'h10; axil.wdata = 32'h0000_2000;
      for (int i = 0; i < 5; i++) begin
         check("stall_bvalid", 32'(axil.bvalid), 32'd1);
         check("stall_awready", 32'(axil.awready), 32'd0);
         check("stall_bresp", 32'(axil.bresp), 32'(exp_resp));
         @(negedge ACLK);
      end
      axil.bready = 1;
      @(negedge ACLK);
      axil.bready = 0;
      check("stall_bvalid_drop", 32'(axil.bvalid), 32'd0);
      wait_sig("second_awready", 0);
      @(negedge ACLK);
      axil.awvalid = 0; axil.wvalid = 0; axil.bready = 1;
      model_write(32'h10, 32'h0000_2000, 4'hF, exp_resp, tp, sp);
      wait_sig("second_bvalid", 1);
      check("second_bresp", 32'(axil.bresp), 32'(exp_resp));
      @(negedge ACLK);
      axil.bready = 0;
      @(negedge ACLK);
      check("second_tail_pulses", 32'(tail_pulses - t0), 32'd1);
      check("second_tail_at_pulse", tail_at_pulse, 32'h0000_2000);
      check_outs("stall");

      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 3);
         idx = $urandom_range(0, 7);
         addr = ($urandom() & 32'hFFFF_FFE0) | (idx << 2);
         data = $urandom();
         if (op <= 1) do_write("rnd_wr", addr, data, 4'($urandom_range(0, 15)), 0);
         else if (op == 2) do_read("rnd_rd", addr);
         else begin
            pulse_evt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_outs("rnd_evt");
         end
      end

      // Reset while a read response is pending; events during reset are ignored
      do_write("pre_rst_desc", 32'h0C, 32'h1234_5678, 4'hF, 0);
      axil.araddr = 32'h0C; axil.arvalid = 1;
      @(negedge ACLK);
      wait_sig("rst_arready", 2);
      @(negedge ACLK);
      axil.arvalid = 0; axil.rready = 0;
      wait_sig("rst_rvalid_pending", 3);
      ARESET = 1; evt_done = 1; evt_err = 1;
      @(negedge ACLK);
      model_reset();
      check("midrd_rvalid", 32'(axil.rvalid), 32'd0);
      check("midrd_bvalid", 32'(axil.bvalid), 32'd0);
      check_outs("midrd");
      @(negedge ACLK);
      evt_done = 0; evt_err = 0; ARESET = 0;
      @(negedge ACLK);
      check("post_rst_rvalid", 32'(axil.rvalid), 32'd0);
      do_read("post_rst_irq", 32'h08);
      do_read("post_rst_desc", 32'h0C);
      do_read("post_rst_ctrl", 32'h00);
      check_outs("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_csr_axil_slave.md
DMA_CSR_AXIL_SLAVE -- requirements
Module: dma_csr_axil_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width; only bits [4:2] are decoded.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width; only 32 is supported.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: ACLK input 1, rising-edge clock for all logic.
REQ-004 ARESET input 1, synchronous active-high reset.
REQ-005 s_axil AW channel: awaddr in ADDR_WIDTH; awvalid in 1; awready out 1.
REQ-006 s_axil W channel: wdata in 32; wstrb in 4; wvalid in 1; wready out 1.
REQ-007 s_axil B channel: bresp out 2; bvalid out 1; bready in 1.
REQ-008 s_axil AR channel: araddr in ADDR_WIDTH; arvalid in 1; arready out 1.
REQ-009 s_axil R channel: rdata out 32; rresp out 2; rvalid out 1; rready in 1.
REQ-010 DMA-side pins: ctrl_run out 1; soft_rst_pulse out 1; desc_addr out 32; tail_addr out 32; tail_wr_pulse out 1; sts_busy in 1; sts_halted in 1; evt_done in 1 (single-cycle pulse); evt_err in 1 (single-cycle pulse); irq out 1.

Function
REQ-011 Register map SHALL be as follows (all other offsets unmapped):
- 0x00 CTRL RW: bit0 run, bit1 soft_rst (self-clearing, reads 0), bit2 irq_en.
- 0x04 STATUS RO: bit0 sts_busy, bit1 sts_halted.
- 0x08 IRQ_STS W1C: bit0 done, bit1 err.
- 0x0C DESC_ADDR RW.
- 0x10 TAIL_ADDR RW.
REQ-012 Write FSM SHALL use W_IDLE -> W_ACK when awvalid && wvalid; W_ACK (awready=wready=1 for exactly one cycle, register updated) -> W_RESP; W_RESP (bvalid=1, held stable) -> W_IDLE on bready.
REQ-013 awready/wready SHALL never assert unless both awvalid and wvalid are high; only one write SHALL be outstanding.
REQ-014 Read FSM SHALL use R_IDLE -> R_ACK on arvalid; R_ACK (arready=1 for one cycle, araddr latched) -> R_DATA; R_DATA (rvalid=1, rdata/rresp stable) -> R_IDLE on rready.
REQ-015 Read and write FSMs SHALL operate concurrently and independently.
REQ-016 A write SHALL update only the bytes whose wstrb bit is 1; wstrb=0 SHALL give bresp OKAY with no change.
REQ-017 Unmapped accesses SHALL return SLVERR (2'b10), change no state, and read rdata=0; a write to STATUS SHALL return OKAY and be ignored.
REQ-018 soft_rst_pulse SHALL be high for one cycle, the cycle after the W_ACK that writes CTRL bit1=1 with wstrb[0]=1.
REQ-019 tail_wr_pulse SHALL be high for one cycle, the cycle after any W_ACK to TAIL_ADDR with nonzero wstrb; tail_addr SHALL already hold the new value in that cycle.
REQ-020 IRQ_STS bits SHALL set on evt_done/evt_err and clear when 1 is written; a set in the same cycle as a clear SHALL win.
REQ-021 irq SHALL be registered and equal irq_en && (done || err) one cycle after the sources change.
REQ-022 STATUS SHALL sample sts_* live in R_ACK.

Reset
REQ-023 ARESET SHALL return both FSMs to IDLE and clear all registers and outputs to 0, including any in-flight response (bvalid=rvalid=0).
REQ-024 A transaction interrupted by ARESET SHALL be dropped with no response generated.
REQ-025 Events arriving during reset SHALL be ignored.

Configuration
REQ-026 With macro DMA_CSR_SCRATCH_EN defined, 0x14 SCRATCH SHALL be a 32-bit RW register, reset 0, honouring wstrb.
REQ-027 Without DMA_CSR_SCRATCH_EN, 0x14 SHALL be unmapped and return SLVERR.

Verification
REQ-028 Write 0x0C=0xDEAD_BEEF with wstrb=0xF, then read 0x0C -> bresp=00, rdata=0xDEADBEEF, rresp=00.
REQ-029 Write TAIL_ADDR=0x0000_1000 -> tail_wr_pulse high for exactly one cycle, tail_addr=0x1000; then write 0x0C with wstrb=0x3 data 0x1111_2222 after 0xDEADBEEF -> read returns 0xDEAD2222.
REQ-030 CTRL=0x7 -> ctrl_run=1, one-cycle soft_rst_pulse, CTRL reads 0x5.
REQ-031 CTRL irq_en=1, evt_done pulse -> IRQ_STS=0x1 and irq=1; write IRQ_STS=0x1 in the same cycle as a new evt_done -> bit stays 1; a later clear -> irq=0.
REQ-032 Read 0x1C and read 0x14 without the macro -> rresp=10, rdata=0; write 0x1C -> bresp=10 and no register change.
REQ-033 bready held low for 5 cycles -> bvalid held and no new awready; ARESET asserted mid-R_DATA -> rvalid=0 next cycle, all registers 0.
